acc_stream_tx: RTL
==================

ACC_STREAM_TX -- requirements
Module: acc_stream_tx

Interface
REQ-001 SHALL have: clk  input  1  clock; all logic on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: load_valid  input  1  load_data holds a word to buffer.
REQ-004 SHALL have: load_data  input  16  word to buffer.
REQ-005 SHALL have: load_ready  output  1  buffer accepts a word this cycle.
REQ-006 SHALL have: go  input  1  single-cycle request to transmit the buffered burst.
REQ-007 SHALL have: start  output  1  start strobe to the downstream accumulator.
REQ-008 SHALL have: sdo  output  16  serial word stream to the accumulator.
REQ-009 SHALL have: acc_finish  input  1  accumulator completion strobe.
REQ-010 SHALL have: acc_sum  input  16  accumulator result, valid while acc_finish=1.
REQ-011 SHALL have: busy  output  1  high in SEND and WAIT.
REQ-012 SHALL have: done  output  1  one-cycle pulse at burst completion or timeout.
REQ-013 SHALL have: err_timeout  output  1  sticky: acc_finish missing.
REQ-014 SHALL have: err_sum  output  1  sticky: checksum mismatch (see Configuration).

Function
REQ-015 SHALL hold an 8 x 16-bit buffer with a 3-bit write pointer and a 4-bit fill count.
REQ-016 SHALL implement states IDLE, READY, SEND, WAIT; all outputs SHALL be registered.
REQ-017 IDLE: load_ready=1; each cycle with load_valid=1 SHALL write buf[wr_ptr] and increment wr_ptr; after the 8th write the block SHALL enter READY next cycle.
REQ-018 READY: load_ready=0; load_valid SHALL be ignored; go=1 SHALL enter SEND.
REQ-019 go SHALL be ignored in IDLE, SEND and WAIT, including a go coincident with the 8th load.
REQ-020 SEND cycle k (k=0..7): sdo=buf[k]; start=1 only at k=0; after k=7 -> WAIT.
REQ-021 Outside SEND, sdo SHALL be 16'h0000 and start SHALL be 0.
REQ-022 Latency: first SEND cycle (start=1) SHALL occur the cycle after go is sampled.
REQ-023 WAIT: acc_finish is expected the cycle after k=7; acc_finish=1 within 4 WAIT cycles SHALL pulse done and return to IDLE.
REQ-024 If 4 WAIT cycles elapse with acc_finish=0, the block SHALL set err_timeout, pulse done, and return to IDLE.
REQ-025 acc_finish outside WAIT SHALL be ignored.
REQ-026 On return to IDLE, fill count and wr_ptr SHALL be 0; buffer contents need not be cleared.
REQ-027 err_timeout and err_sum SHALL clear on the cycle go is accepted in READY.

Reset
REQ-028 rst SHALL force IDLE, wr_ptr=0, count=0, load_ready=1, start=0, sdo=0, busy=0, done=0, err_timeout=0, err_sum=0, running sum=0.
REQ-029 rst asserted mid-SEND or mid-WAIT SHALL abort the burst; start/sdo SHALL be 0 from the next cycle and done SHALL NOT pulse.

Configuration
REQ-030 Macro ACC_STREAM_TX_CHECK_EN defined: the block SHALL accumulate the 8 transmitted words mod 2^16 during SEND and, on acc_finish in WAIT, set err_sum if acc_sum differs from that sum.
REQ-031 Macro ACC_STREAM_TX_CHECK_EN undefined: acc_sum SHALL be ignored, the sum logic SHALL be absent, and err_sum SHALL be constant 0.

Verification
REQ-032 Load 1..8, go; acc model returns 16'h0024 one cycle after k=7 -> start at k=0, sdo 1..8, done one cycle after acc_finish, err_sum=0, err_timeout=0.
REQ-033 Load 8 x 16'hFFFF, go; acc returns 16'hFFF8 -> err_sum=0; same burst with acc returning 16'hFFF7 -> err_sum=1 with CHECK_EN, 0 without.
REQ-034 Full burst with acc_finish held 0 -> done and err_timeout=1 after 4 WAIT cycles, state IDLE, load_ready=1; next accepted go clears err_timeout.
REQ-035 go pulsed in IDLE after 5 loads, and coincident with the 8th load -> no start; a later go in READY starts the burst.
REQ-036 rst at SEND k=3 -> start=0, sdo=0, busy=0 next cycle, no done; reload 8 words and go -> normal burst.

Source files
------------

// File: rtl/acc_stream_tx_if.sv
// Load/transmit/accumulator signal bundle for acc_stream_tx.
// master: the transmitter; slave: the loader, requester and accumulator around it.
interface acc_stream_tx_if;
   logic        load_valid;
   logic [15:0] load_data;
   logic        load_ready;
   logic        go;
   logic        start;
   logic [15:0] sdo;
   logic        acc_finish;
   logic [15:0] acc_sum;
   logic        busy;
   logic        done;
   logic        err_timeout;
   logic        err_sum;

   modport master (
      input  load_valid, load_data, go, acc_finish, acc_sum,
      output load_ready, start, sdo, busy, done, err_timeout, err_sum
   );

   modport slave (
      output load_valid, load_data, go, acc_finish, acc_sum,
      input  load_ready, start, sdo, busy, done, err_timeout, err_sum
   );
endinterface

// File: rtl/acc_stream_tx.sv
// Buffers an 8-word burst, streams it to an accumulator and waits for its result.
// Define ACC_STREAM_TX_CHECK_EN to check acc_sum against a locally kept checksum.
module acc_stream_tx (
   input  logic clk,
   input  logic rst,
   acc_stream_tx_if.master bus
);

   typedef enum logic [1:0] {IDLE, READY, SEND, WAIT} state_t;

   state_t      state_reg, state_next;
   logic [2:0]  wr_ptr_reg, wr_ptr_next;
   logic [3:0]  count_reg, count_next;
   logic [2:0]  k_reg, k_next;
   logic [1:0]  wait_reg, wait_next;
   logic        load_ready_reg, busy_reg;
   logic        start_reg, start_next;
   logic        done_reg, done_next;
   logic        err_timeout_reg, err_timeout_next;
   logic [15:0] sdo_reg;
   logic [15:0] buf_mem [8];
   logic        wr_en;
   logic        rd_en;
   logic [2:0]  rd_addr;
   logic        go_accept;
   logic        finish_hit;

   assign go_accept  = (state_reg == READY) && bus.go;
   assign finish_hit = (state_reg == WAIT) && bus.acc_finish;

   always_comb begin
      state_next       = state_reg;
      wr_ptr_next      = wr_ptr_reg;
      count_next       = count_reg;
      k_next           = k_reg;
      wait_next        = wait_reg;
      start_next       = 1'b0;
      done_next        = 1'b0;
      err_timeout_next = err_timeout_reg;
      wr_en            = 1'b0;
      rd_en            = 1'b0;
      rd_addr          = 3'd0;
      case (state_reg)
         IDLE: begin
            if (bus.load_valid) begin
               wr_en       = 1'b1;
               wr_ptr_next = wr_ptr_reg + 3'd1;
               count_next  = count_reg + 4'd1;
               if (count_reg == 4'd7) state_next = READY;
            end
         end
         READY: begin
            if (go_accept) begin
               state_next       = SEND;
               k_next           = 3'd0;
               rd_en            = 1'b1;
               rd_addr          = 3'd0;
               start_next       = 1'b1;
               err_timeout_next = 1'b0;
            end
         end
         SEND: begin
            if (k_reg == 3'd7) begin
               state_next = WAIT;
               wait_next  = 2'd0;
            end else begin
               k_next  = k_reg + 3'd1;
               rd_en   = 1'b1;
               rd_addr = k_reg + 3'd1;
            end
         end
         WAIT: begin
            // A finish in the last WAIT cycle still counts as on time.
            if (finish_hit || wait_reg == 2'd3) begin
               if (!finish_hit) err_timeout_next = 1'b1;
               done_next   = 1'b1;
               state_next  = IDLE;
               wr_ptr_next = 3'd0;
               count_next  = 4'd0;
            end else begin
               wait_next = wait_reg + 2'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         wr_ptr_reg      <= 3'd0;
         count_reg       <= 4'd0;
         k_reg           <= 3'd0;
         wait_reg        <= 2'd0;
         load_ready_reg  <= 1'b1;
         busy_reg        <= 1'b0;
         start_reg       <= 1'b0;
         done_reg        <= 1'b0;
         err_timeout_reg <= 1'b0;
         sdo_reg         <= 16'h0000;
      end else begin
         state_reg       <= state_next;
         wr_ptr_reg      <= wr_ptr_next;
         count_reg       <= count_next;
         k_reg           <= k_next;
         wait_reg        <= wait_next;
         load_ready_reg  <= (state_next == IDLE);
         busy_reg        <= (state_next == SEND) || (state_next == WAIT);
         start_reg       <= start_next;
         done_reg        <= done_next;
         err_timeout_reg <= err_timeout_next;
         sdo_reg         <= rd_en ? buf_mem[rd_addr] : 16'h0000;
      end
   end

   // Buffer contents survive reset and return to IDLE; only the pointers clear.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) buf_mem[wr_ptr_reg] <= bus.load_data;
   end

   assign bus.load_ready  = load_ready_reg;
   assign bus.busy        = busy_reg;
   assign bus.start       = start_reg;
   assign bus.done        = done_reg;
   assign bus.err_timeout = err_timeout_reg;
   assign bus.sdo         = sdo_reg;

`ifdef ACC_STREAM_TX_CHECK_EN
   logic [15:0] sum_reg, sum_next;
   logic        err_sum_reg, err_sum_next;

   // The sum follows the words actually placed on sdo during SEND.
   always_comb begin
      sum_next     = sum_reg;
      err_sum_next = err_sum_reg;
      if (go_accept) begin
         sum_next     = 16'h0000;
         err_sum_next = 1'b0;
      end else if (state_reg == SEND) begin
         sum_next = sum_reg + sdo_reg;
      end
      if (finish_hit && (bus.acc_sum != sum_reg)) err_sum_next = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_reg     <= 16'h0000;
         err_sum_reg <= 1'b0;
      end else begin
         sum_reg     <= sum_next;
         err_sum_reg <= err_sum_next;
      end
   end

   assign bus.err_sum = err_sum_reg;
`else
   logic unused_acc_sum;
   assign unused_acc_sum = ^bus.acc_sum;
   assign bus.err_sum    = 1'b0;
`endif

endmodule
